// File: rtl/instr_fetch_mem.sv
// instr_fetch_mem: word memory with a load port and a multi-word instruction fetch FSM.
// Define IFM_PARITY_EN to store a per-word even-parity bit and report mismatches on fetch.
module instr_fetch_mem #(
    parameter int ADDR_WIDTH   = 6,
    parameter int DATA_WIDTH   = 8,
    parameter int OPCODE_WIDTH = 3,
    parameter int NUM_OPERANDS = 2
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             wr_en,
    input  logic [ADDR_WIDTH-1:0]            wr_addr,
    input  logic [DATA_WIDTH-1:0]            wr_data,
    input  logic                             wr_par_inv,
    input  logic                             req_valid,
    output logic                             req_ready,
    input  logic [ADDR_WIDTH-1:0]            req_addr,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [OPCODE_WIDTH-1:0]          opcode,
    output logic [NUM_OPERANDS*DATA_WIDTH-1:0] operands,
    output logic [ADDR_WIDTH-1:0]            out_pc,
    output logic [ADDR_WIDTH-1:0]            next_pc,
    output logic                             out_parity_err
);
    localparam int MEM_SIZE = 2 ** ADDR_WIDTH;
    localparam int N = 1 + NUM_OPERANDS;
    localparam logic [ADDR_WIDTH-1:0] NSTEP = ADDR_WIDTH'(N);
    localparam logic [2:0] LAST = 3'(N - 1);

    typedef enum logic [1:0] {IDLE, FETCH, HOLD} state_t;

    state_t                 state, state_nxt;
    logic [2:0]             cnt;
    logic [ADDR_WIDTH-1:0]  base, rd_addr;
    logic [DATA_WIDTH-1:0]  mem [MEM_SIZE];
    logic [DATA_WIDTH-1:0]  rd_data;
    logic                   wr_ok, wr_hit, rd_err;

    assign wr_ok   = wr_en && !rst;
    assign rd_addr = base + ADDR_WIDTH'(cnt);
    assign wr_hit  = wr_ok && wr_addr == rd_addr;
    // same-cycle write to the word being read wins over the stored copy
    assign rd_data = wr_hit ? wr_data : mem[rd_addr];

    always_ff @(posedge clk)
        if (wr_ok) mem[wr_addr] <= wr_data;

`ifdef IFM_PARITY_EN
    logic par [MEM_SIZE];
    logic wr_par, rd_par;
    assign wr_par = ^wr_data ^ wr_par_inv;
    assign rd_par = wr_hit ? wr_par : par[rd_addr];
    assign rd_err = rd_par ^ (^rd_data);
    always_ff @(posedge clk)
        if (wr_ok) par[wr_addr] <= wr_par;
`else
    logic unused_par_inv;
    assign unused_par_inv = wr_par_inv;
    assign rd_err = 1'b0;
`endif

    assign req_ready = state == IDLE;
    assign out_valid = state == HOLD;

    always_comb
        state_nxt = (state == IDLE && req_valid)   ? FETCH :
                    (state == FETCH && cnt == LAST) ? HOLD  :
                    (state == HOLD && out_ready)    ? IDLE  : state;

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state          <= IDLE;
            cnt            <= '0;
            base           <= '0;
            opcode         <= '0;
            operands       <= '0;
            out_pc         <= '0;
            next_pc        <= '0;
            out_parity_err <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && req_valid) begin
                base <= req_addr;
                cnt  <= '0;
            end
            if (state == FETCH) begin
                cnt <= cnt + 3'd1;
                if (cnt == 3'd0) begin
                    opcode         <= rd_data[OPCODE_WIDTH-1:0];
                    out_parity_err <= rd_err;
                end else
                    out_parity_err <= out_parity_err | rd_err;
                for (int k = 0; k < NUM_OPERANDS; k++)
                    if (cnt == 3'(k + 1)) operands[k*DATA_WIDTH +: DATA_WIDTH] <= rd_data;
                if (cnt == LAST) begin
                    out_pc  <= base;
                    next_pc <= base + NSTEP;
                end
            end
        end
endmodule

// File: doc/instr_fetch_mem.md
INSTR_FETCH_MEM -- requirements
Module: instr_fetch_mem

Interface
REQ-001 Parameter ADDR_WIDTH, default 6, word-address width.
REQ-002 Parameter DATA_WIDTH, default 8, width of one memory word.
REQ-003 Parameter OPCODE_WIDTH, default 3, opcode field width; legal range 1..DATA_WIDTH.
REQ-004 Parameter NUM_OPERANDS, default 2, operand words per instruction; legal range 1..4.
REQ-005 Derived MEM_SIZE = 2**ADDR_WIDTH words; derived N = 1+NUM_OPERANDS words per instruction.
REQ-006 clk  input  1  single clock; all state updates on posedge.
REQ-007 rst  input  1  reset, asynchronous, active-high.
REQ-008 wr_en  input  1  load-port write strobe.
REQ-009 wr_addr  input  ADDR_WIDTH  load-port word address.
REQ-010 wr_data  input  DATA_WIDTH  load-port write data.
REQ-011 wr_par_inv  input  1  store inverted parity for this write (fault injection; ignored unless parity is compiled in).
REQ-012 req_valid  input  1  fetch request valid.
REQ-013 req_ready  output  1  fetch request can be accepted.
REQ-014 req_addr  input  ADDR_WIDTH  address of the opcode word.
REQ-015 out_valid  output  1  fetched instruction valid.
REQ-016 out_ready  input  1  consumer accepts the instruction.
REQ-017 opcode  output  OPCODE_WIDTH  word0[OPCODE_WIDTH-1:0].
REQ-018 operands  output  NUM_OPERANDS*DATA_WIDTH  operand k at bits [k*DATA_WIDTH +: DATA_WIDTH], k=0 first.
REQ-019 out_pc  output  ADDR_WIDTH  address of the fetched instruction.
REQ-020 next_pc  output  ADDR_WIDTH  (out_pc + N) mod MEM_SIZE.
REQ-021 out_parity_err  output  1  parity mismatch in any word of this instruction.

Function
REQ-022 FSM states IDLE, FETCH, HOLD; req_ready = 1 only in IDLE.
REQ-023 IDLE -> FETCH when req_valid && req_ready; req_addr is captured and the word counter is cleared.
REQ-024 FETCH reads exactly one word per cycle, word k from (captured addr + k) mod MEM_SIZE, k = 0..N-1.
REQ-025 FETCH -> HOLD after word N-1 is read; out_valid rises exactly N clock edges after the accepting edge.
REQ-026 HOLD keeps opcode, operands, out_pc, next_pc and out_parity_err stable while out_valid && !out_ready.
REQ-027 HOLD -> IDLE on out_valid && out_ready; out_valid falls on that edge; the next request is accepted no earlier than the following edge.
REQ-028 Address arithmetic wraps modulo MEM_SIZE: an instruction at MEM_SIZE-1 reads words MEM_SIZE-1, 0, 1, ...
REQ-029 Load-port writes are accepted in every state, one word per cycle, with no back-pressure.
REQ-030 A write and a FETCH read to the same address in the same cycle return the new data (write-first).
REQ-031 Writes to words of an instruction already read or held do not alter the held outputs.
REQ-032 req_valid in FETCH or HOLD is ignored and not queued.
REQ-033 Opcode bits of word0 above OPCODE_WIDTH are discarded.

Reset
REQ-034 Asserting rst forces IDLE, clears the word counter and drives out_valid=0, opcode=0, operands=0, out_pc=0, next_pc=0, out_parity_err=0 immediately.
REQ-035 req_ready = 1 while rst is asserted and in the first cycle after deassertion.
REQ-036 Memory contents are not cleared by reset; a fetch in flight when reset asserts is abandoned with no output.
REQ-037 Writes presented while rst is asserted are ignored.

Configuration
REQ-038 Macro IFM_PARITY_EN, when defined: every word stores an even-parity bit computed on write and inverted when wr_par_inv=1; out_parity_err = OR of mismatches over the N words, valid with out_valid.
REQ-039 Without IFM_PARITY_EN: no parity storage, wr_par_inv ignored, out_parity_err tied 0; all other behaviour is identical.

Verification
REQ-040 Load 0x05,0x11,0x22 at 0..2, fetch addr 0 -> out_valid 3 edges after accept; opcode=5, operands={0x22,0x11}, out_pc=0, next_pc=3.
REQ-041 Default params, load 0x07,0xAA,0xBB at 63,0,1, fetch 63 -> opcode=7, operand0=0xAA, operand1=0xBB, next_pc=2.
REQ-042 Hold out_ready=0 for 5 cycles in HOLD with req_valid=1 and writes to the fetched words -> outputs stable, req_ready=0, no new fetch; out_ready=1 -> IDLE.
REQ-043 Write 0x33 to addr+1 in the same cycle operand0 is read -> operand0=0x33.
REQ-044 Assert rst mid-FETCH -> out_valid=0 and req_ready=1 immediately; a refetch returns the pre-reset memory contents.
REQ-045 With IFM_PARITY_EN, write addr 2 with wr_par_inv=1, fetch 0 -> out_parity_err=1; rewrite it with wr_par_inv=0 and refetch -> 0; without the macro -> always 0.
